// File: rtl/alu_mc.sv
// alu_mc: ALU with single-cycle ops and an optional multi-cycle shift-add MUL.
// Define ALU_MC_MUL_EN to build the MUL datapath and BUSY state.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             in_enable_out,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_valid,
  output logic [3:0]       flags
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_COMP = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd8;
  localparam logic [3:0] OP_SBB  = 4'd9;
`ifdef ALU_MC_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`endif

  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] hi_q;
  logic [3:0]       flags_q;
  logic             valid_q;
  logic             fire;

  logic [WIDTH-1:0] res_d;
  logic [3:0]       flags_d;
  logic             cin;
  logic [WIDTH:0]   ua, ub, sa, sb, cx;
  logic [WIDTH:0]   add_u, add_s, sub_u, sub_s;
  logic             c_d, o_d;

  assign fire = in_valid & in_ready;
  assign cin  = flags_q[3];

`ifdef ALU_MC_MUL_EN
  typedef enum logic {S_IDLE, S_BUSY} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] mc_q, ml_q, mh_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] mh_n, ml_n;
  logic             last;
  logic             fire_mul;

  assign fire_mul = fire && (op == OP_MUL);
  assign last     = (cnt_q == CW'(WIDTH - 1));

  // One shift-add step: add multiplicand into high half, shift pair right
  always_comb begin
    step_sum = {1'b0, mh_q} + (ml_q[0] ? {1'b0, mc_q} : '0);
    mh_n     = step_sum[WIDTH:1];
    ml_n     = {step_sum[0], ml_q[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake: MUL holds BUSY for WIDTH steps
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (fire_mul) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Multiplier operand and partial-product registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_q  <= '0;
      ml_q  <= '0;
      mh_q  <= '0;
      cnt_q <= '0;
    end else if (fire_mul) begin
      mc_q  <= in_A;
      ml_q  <= in_B;
      mh_q  <= '0;
      cnt_q <= '0;
    end else if (state_q == S_BUSY) begin
      ml_q  <= ml_n;
      mh_q  <= mh_n;
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign in_ready = 1'b1;
`endif

  // Single-cycle result and flags, computed from the presented operands
  always_comb begin
    ua    = {1'b0, in_A};
    ub    = {1'b0, in_B};
    sa    = {in_A[WIDTH-1], in_A};
    sb    = {in_B[WIDTH-1], in_B};
    cx    = {{WIDTH{1'b0}}, ((op == OP_ADC) || (op == OP_SBB)) & cin};
    add_u = ua + ub + cx;
    add_s = sa + sb + cx;
    sub_u = ua - ub - cx;
    sub_s = sa - sb - cx;
    res_d = '0;
    c_d   = 1'b0;
    o_d   = 1'b0;
    unique case (op)
      OP_ADD, OP_ADC: begin
        res_d = add_u[WIDTH-1:0];
        c_d   = add_u[WIDTH];
        o_d   = add_s[WIDTH] ^ add_s[WIDTH-1];
      end
      OP_SUB, OP_SBB: begin
        res_d = sub_u[WIDTH-1:0];
        c_d   = sub_u[WIDTH];
        o_d   = sub_s[WIDTH] ^ sub_s[WIDTH-1];
      end
      OP_OR:   res_d = in_A | in_B;
      OP_AND:  res_d = in_A & in_B;
      OP_NOT:  res_d = ~in_A;
      OP_COMP: res_d = {{(WIDTH-1){1'b0}}, in_A == in_B};
      OP_SHR:  res_d = {1'b0, in_A[WIDTH-1:1]};
      OP_SHL:  res_d = {in_A[WIDTH-2:0], 1'b0};
      default: res_d = '0;
    endcase
    flags_d = {c_d, res_d[WIDTH-1], o_d, ~|res_d};
  end

  // Result, flag and valid-pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
`ifdef ALU_MC_MUL_EN
      if (fire && !fire_mul) begin
`else
      if (fire) begin
`endif
        res_q   <= res_d;
        hi_q    <= '0;
        flags_q <= flags_d;
        valid_q <= 1'b1;
      end
`ifdef ALU_MC_MUL_EN
      if ((state_q == S_BUSY) && last) begin
        res_q   <= ml_n;
        hi_q    <= mh_n;
        flags_q <= {|mh_n, ml_n[WIDTH-1], 1'b0, ~|ml_n};
        valid_q <= 1'b1;
      end
`endif
    end
  end

  assign out       = in_enable_out ? res_q : {WIDTH{1'bz}};
  assign out_hi    = in_enable_out ? hi_q  : {WIDTH{1'bz}};
  assign out_valid = valid_q;
  assign flags     = flags_q;

endmodule
